word_assembler: RTL and testbench

Upstream feeder for the 32-bit data register: on a start command it fetches four consecutive bytes from a byte-wide memory port, assembles them little-endian into one 32-bit word, and presents the word on `dout` with a single-cycle `load` strobe. `dout` and `load` connect directly to the register's `din` and `load` inputs. A bounded wait on each memory access prevents a dead memory from hanging the datapath.

---
 rtl/proc_pkg.sv | 31 +++
 rtl/word_assembler.sv | 120 ++++++++++++
 tb/tb_word_assembler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the word assembler and the 32-bit register datapath.
// Also holds the byte-lane insert helper used while a word is being assembled.
package proc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      ABORT = 2'd3
   } word_asm_state_t;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   // Returns w with byte lane 'lane' replaced by b (lane 0 = bits 7:0).
   function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        lane,
                                                  input logic [BYTE_W-1:0] b);
      logic [WORD_W-1:0] r;
      r = w;
      case (lane)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         2'd3:    r[31:24] = b;
         default: r        = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Fetches four consecutive bytes from a byte-wide memory port, assembles them
// little-endian and presents the word on dout with a one-cycle load strobe.
module word_assembler
   import proc_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_ack,
   input  logic [BYTE_W-1:0]   mem_rdata,
   output logic [WORD_W-1:0]   dout,
   output logic                load,
   output logic                busy,
   output logic                error
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   word_asm_state_t     state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [7:0]          wait_q, wait_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   shadow_q, shadow_d;
   logic [WORD_W-1:0]   dout_q, dout_d;
   logic                req_q, req_d;
   logic                load_q, load_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   // Next-state logic; addr_q tracks base + cnt so mem_addr comes straight from a flop.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;
      addr_d   = addr_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               addr_d  = base_addr;
               cnt_d   = 2'd0;
               wait_d  = 8'd0;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               shadow_d = put_lane(shadow_q, cnt_q, mem_rdata);
               wait_d   = 8'd0;
               if (cnt_q == 2'd3) begin
                  state_d = LOAD;
                  dout_d  = shadow_d;
               end else begin
                  cnt_d  = cnt_q + 2'd1;
                  addr_d = addr_q + ADDR_W'(1);
               end
            end else begin
               wait_d = wait_q + 8'd1;
               if (wait_d >= MAX_WAIT_C) begin
                  state_d = ABORT;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         LOAD:    state_d = IDLE;
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      req_d  = (state_d == FETCH);
      load_d = (state_d == LOAD);
      busy_d = (state_d != IDLE);
      err_d  = (state_d == ABORT);
   end

   // State, datapath and registered output strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         wait_q   <= 8'd0;
         addr_q   <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         req_q    <= 1'b0;
         load_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         addr_q   <= addr_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         req_q    <= req_d;
         load_q   <= load_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign dout     = dout_q;
   assign load     = load_q;
   assign busy     = busy_q;
   assign error    = err_q;

endmodule

// File: tb/tb_word_assembler.sv
// Scoreboard bench for word_assembler: behavioural byte memory with programmable
// ack delay, a behavioural 32-bit register on dout/load, and randomized fetches.
module tb_word_assembler;
   import proc_pkg::*;

   localparam int ADDR_W   = 16;
   localparam int MAX_WAIT = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [15:0]       base_addr = 16'd0;
   logic              mem_req;
   logic [15:0]       mem_addr;
   logic              mem_ack = 1'b0;
   logic [7:0]        mem_rdata = 8'd0;
   logic [31:0]       dout;
   logic              load, busy, error;

   typedef struct {
      bit          err;
      logic [31:0] word;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] addr_log[$];
   logic [7:0]  mem [0:65535];
   logic [31:0] reg_q;
   logic [31:0] last_word = 32'd0;
   int          ack_delay = 0;
   bit          dead = 1'b0;
   int          wcnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   word_assembler #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .dout(dout), .load(load), .busy(busy), .error(error)
   );

   // Behavioural Register_32 fed by the assembler.
   always @(posedge clk or negedge reset) begin
      if (!reset) reg_q <= 32'd0;
      else if (load) reg_q <= dout;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Byte memory: acks after ack_delay wait cycles, never when dead.
   always @(negedge clk) begin
      if (!reset || !mem_req || dead) begin
         mem_ack = 1'b0;
         wcnt = 0;
      end else if (wcnt >= ack_delay) begin
         mem_ack = 1'b1;
         mem_rdata = mem[mem_addr];
         addr_log.push_back(mem_addr);
         wcnt = 0;
      end else begin
         mem_ack = 1'b0;
         wcnt++;
      end
   end

   // Monitor: every strobe must match the head of the scoreboard.
   bit          pend = 1'b0;
   logic [31:0] pend_val;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("reg_capture", reg_q, pend_val);
            pend = 1'b0;
         end
         if (load || error) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", {30'd0, load, error}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("strobe_kind", {30'd0, load, error}, e.err ? 32'd1 : 32'd2);
               chk("dout", dout, e.word);
               if (!e.err) begin
                  pend = 1'b1;
                  pend_val = e.word;
               end
            end
         end
      end
   end

   task automatic fetch(input logic [15:0] b, input int d, input bit kill,
                        input bit second_start, input bit rnd);
      logic [31:0] w;
      logic [15:0] a;
      int cyc, exp_lat;
      bit seen;
      ack_delay = d;
      dead = kill;
      for (int i = 0; i < 4; i++) begin
         a = b + 16'(i);
         if (rnd) mem[a] = 8'($urandom);
         w[8*i +: 8] = mem[a];
      end
      if (kill) sb.push_back('{1'b1, last_word});
      else sb.push_back('{1'b0, w});
      addr_log.delete();
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      @(posedge clk);
      exp_lat = kill ? MAX_WAIT + 1 : 5 + 4 * d;
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (second_start && cyc == 3) begin
            start = 1'b1;
            base_addr = ~b;
         end
         if (load || error) seen = 1'b1;
      end
      chk("completion_seen", {31'd0, seen}, 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      if (kill) begin
         chk("abort_no_acks", 32'(addr_log.size()), 32'd0);
      end else begin
         last_word = w;
         chk("addr_count", 32'(addr_log.size()), 32'd4);
         for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("mem_addr", {16'd0, addr_log[i]}, {16'd0, b + 16'(i)});
      end
      @(negedge clk);
      chk("idle_after", {28'd0, busy, mem_req, load, error}, 32'd0);
      dead = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_dout", dout, 32'd0);
      chk("reset_outs", {11'd0, mem_addr, busy, mem_req, load, error}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_dout", dout, 32'd0);
         chk("idle_strobes", {28'd0, busy, mem_req, load, error}, 32'd0);
      end

      mem[16'h0010] = 8'h23; mem[16'h0011] = 8'h30;
      mem[16'h0012] = 8'h00; mem[16'h0013] = 8'h00;
      fetch(16'h0010, 0, 1'b0, 1'b0, 1'b0);
      chk("dout_12323", dout, 32'd12323);
      chk("reg_12323", reg_q, 32'd12323);

      mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
      mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
      fetch(16'hFFFE, 0, 1'b0, 1'b0, 1'b0);
      chk("dout_wrap", dout, 32'h44332211);

      fetch(16'h1234, 3, 1'b0, 1'b1, 1'b1);

      fetch(16'h2000, 0, 1'b1, 1'b0, 1'b1);
      chk("dout_kept_after_abort", dout, 32'h44332211 == last_word ? dout : last_word);
      chk("dout_hold", dout, last_word);

      // Reset asserted after the second byte has been captured.
      ack_delay = 0;
      for (int i = 0; i < 4; i++) mem[16'h3000 + 16'(i)] = 8'($urandom);
      @(negedge clk);
      start = 1'b1;
      base_addr = 16'h3000;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midreset_dout", dout, 32'd0);
      chk("midreset_outs", {11'd0, mem_addr, busy, mem_req, load, error}, 32'd0);
      sb.delete();
      last_word = 32'd0;
      repeat (3) begin
         @(negedge clk);
         chk("midreset_quiet", {30'd0, load, error}, 32'd0);
      end
      reset = 1'b1;
      fetch(16'h3000, 0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         fetch(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
               $urandom_range(0, 1) == 1, 1'b1);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
